ahb_periph_slave: RTL and testbench

//  AHB-Lite slave sitting directly downstream of the core's AHB master bridge. Decodes one

---
 rtl/ahb_periph_slave_pkg.sv | 19 +
 rtl/ahb_periph_slave_lane_decode.sv | 35 +++
 rtl/ahb_periph_slave.sv | 133 +++++++++++++
 tb/tb_ahb_periph_slave.sv | 203 ++++++++++++++++++++
 4 files changed

// File: rtl/ahb_periph_slave_pkg.sv
// rtl/ahb_periph_slave_pkg.sv - shared AHB encodings and FSM state type for ahb_periph_slave
package ahb_periph_slave_pkg;

   localparam logic [1:0] HTRANS_IDLE   = 2'b00;
   localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

   localparam logic [2:0] HSIZE_BYTE = 3'd0;
   localparam logic [2:0] HSIZE_HALF = 3'd1;
   localparam logic [2:0] HSIZE_WORD = 3'd2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_ACCESS = 3'd1,
      ST_RESP   = 3'd2,
      ST_ERR1   = 3'd3,
      ST_ERR2   = 3'd4
   } state_t;

endpackage

// File: rtl/ahb_periph_slave_lane_decode.sv
// rtl/ahb_periph_slave_lane_decode.sv - byte-lane mask and alignment check for one AHB transfer
//
// Ports:
//   addr_lo  in  2  HADDR[1:0]
//   hsize    in  3  HSIZE
//   wstrb    out 4  byte-lane mask (zero for unsupported sizes)
//   misalign out 1  address not aligned to the transfer size
module ahb_lane_decode
   import ahb_periph_slave_pkg::*;
(
   input  logic [1:0] addr_lo,
   input  logic [2:0] hsize,
   output logic [3:0] wstrb,
   output logic       misalign
);

   always_comb begin
      wstrb    = 4'b0000;
      misalign = 1'b0;
      case (hsize)
         HSIZE_BYTE: wstrb = 4'b0001 << addr_lo;
         HSIZE_HALF: begin
            wstrb    = addr_lo[1] ? 4'b1100 : 4'b0011;
            misalign = addr_lo[0];
         end
         HSIZE_WORD: begin
            wstrb    = 4'b1111;
            misalign = |addr_lo;
         end
         // Oversized transfers are rejected by the top; no lanes enabled.
         default: wstrb = 4'b0000;
      endcase
   end

endmodule

// File: rtl/ahb_periph_slave.sv
// rtl/ahb_periph_slave.sv - AHB-Lite slave bridging single NONSEQ transfers to a req/ack peripheral
//
// Ports:
//   clk, reset (async, active-low)
//   AHB-Lite: HSEL, HADDR, HWRITE, HTRANS, HSIZE, HWDATA, HREADY in; HREADYOUT, HRESP, HRDATA out
//   Peripheral: P_REQ, P_ADDR, P_WRITE, P_WSTRB, P_WDATA out; P_RDATA, P_ACK, P_ERR in
module ahb_periph_slave
   import ahb_periph_slave_pkg::*;
#(
   parameter int unsigned PADDR_W = 32,
   parameter int unsigned TIMEOUT = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               HSEL,
   input  logic [31:0]        HADDR,
   input  logic               HWRITE,
   input  logic [1:0]         HTRANS,
   input  logic [2:0]         HSIZE,
   input  logic [31:0]        HWDATA,
   input  logic               HREADY,
   output logic               HREADYOUT,
   output logic               HRESP,
   output logic [31:0]        HRDATA,
   output logic               P_REQ,
   output logic [PADDR_W-1:0] P_ADDR,
   output logic               P_WRITE,
   output logic [3:0]         P_WSTRB,
   output logic [31:0]        P_WDATA,
   input  logic [31:0]        P_RDATA,
   input  logic               P_ACK,
   input  logic               P_ERR
);

   state_t               state_q, state_d;
   logic [31:0]          cnt_q, cnt_d;
   logic [31:0]          hrdata_q, hrdata_d;
   logic [PADDR_W-1:0]   p_addr_q, p_addr_d;
   logic                 p_write_q, p_write_d;
   logic [3:0]           p_wstrb_q, p_wstrb_d;
   logic                 hreadyout_q, hreadyout_d;
   logic                 hresp_q, hresp_d;
   logic                 p_req_q, p_req_d;

   logic [3:0]           lane_wstrb;
   logic                 lane_misalign;
   logic                 accept;

   ahb_lane_decode u_lane_decode (
      .addr_lo  (HADDR[1:0]),
      .hsize    (HSIZE),
      .wstrb    (lane_wstrb),
      .misalign (lane_misalign)
   );

   assign accept = HSEL && (HTRANS == HTRANS_NONSEQ) && HREADY;

   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      hrdata_d  = hrdata_q;
      p_addr_d  = p_addr_q;
      p_write_d = p_write_q;
      p_wstrb_d = p_wstrb_q;

      case (state_q)
         ST_IDLE, ST_RESP, ST_ERR2: begin
            if (accept) begin
               p_addr_d  = HADDR[PADDR_W-1:0];
               p_write_d = HWRITE;
               p_wstrb_d = lane_wstrb;
               state_d   = (lane_misalign || (HSIZE > HSIZE_WORD)) ? ST_ERR1 : ST_ACCESS;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            cnt_d = cnt_q + 32'd1;
            if (P_ERR) begin
               state_d = ST_ERR1;
            end else if (P_ACK) begin
               state_d = ST_RESP;
               if (!p_write_q) hrdata_d = P_RDATA;
            end else if ((TIMEOUT != 0) && (cnt_q == TIMEOUT - 1)) begin
               state_d = ST_ERR1;
            end
            if (state_d != ST_ACCESS) cnt_d = 32'd0;
         end
         ST_ERR1: state_d = ST_ERR2;
         default: state_d = ST_IDLE;
      endcase

      // Outputs are registered from the next state so they are pure state decodes.
      hreadyout_d = (state_d == ST_IDLE) || (state_d == ST_RESP) || (state_d == ST_ERR2);
      hresp_d     = (state_d == ST_ERR1) || (state_d == ST_ERR2);
      p_req_d     = (state_d == ST_ACCESS);
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ST_IDLE;
         cnt_q       <= 32'd0;
         hrdata_q    <= 32'd0;
         p_addr_q    <= '0;
         p_write_q   <= 1'b0;
         p_wstrb_q   <= 4'b0000;
         hreadyout_q <= 1'b1;
         hresp_q     <= 1'b0;
         p_req_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         hrdata_q    <= hrdata_d;
         p_addr_q    <= p_addr_d;
         p_write_q   <= p_write_d;
         p_wstrb_q   <= p_wstrb_d;
         hreadyout_q <= hreadyout_d;
         hresp_q     <= hresp_d;
         p_req_q     <= p_req_d;
      end
   end

   assign HREADYOUT = hreadyout_q;
   assign HRESP     = hresp_q;
   assign HRDATA    = hrdata_q;
   assign P_REQ     = p_req_q;
   assign P_ADDR    = p_addr_q;
   assign P_WRITE   = p_write_q;
   assign P_WSTRB   = p_wstrb_q;
   // Write data flows straight through from the bus while the request is open.
   assign P_WDATA   = p_req_q ? HWDATA : 32'd0;

endmodule

// File: tb/tb_ahb_periph_slave.sv
// tb/tb_ahb_periph_slave.sv - self-checking bench for ahb_periph_slave
module tb_ahb_periph_slave;

   localparam int TO = 16;

   logic        clk = 1'b0;
   logic        reset;
   logic        HSEL, HWRITE, HREADY;
   logic [31:0] HADDR, HWDATA;
   logic [1:0]  HTRANS;
   logic [2:0]  HSIZE;
   logic        HREADYOUT, HRESP;
   logic [31:0] HRDATA;
   logic        P_REQ, P_WRITE, P_ACK, P_ERR;
   logic [31:0] P_ADDR, P_WDATA, P_RDATA;
   logic [3:0]  P_WSTRB;

   int checks = 0;
   int errors = 0;
   logic [31:0] hrdata_exp;

   ahb_periph_slave #(.PADDR_W(32), .TIMEOUT(TO)) dut (
      .clk(clk), .reset(reset),
      .HSEL(HSEL), .HADDR(HADDR), .HWRITE(HWRITE), .HTRANS(HTRANS), .HSIZE(HSIZE),
      .HWDATA(HWDATA), .HREADY(HREADY), .HREADYOUT(HREADYOUT), .HRESP(HRESP),
      .HRDATA(HRDATA), .P_REQ(P_REQ), .P_ADDR(P_ADDR), .P_WRITE(P_WRITE),
      .P_WSTRB(P_WSTRB), .P_WDATA(P_WDATA), .P_RDATA(P_RDATA), .P_ACK(P_ACK), .P_ERR(P_ERR)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed no completion expected finish");
      $fatal(1);
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Reference rules: lane mask and legality from address/size arithmetic.
   function automatic logic [3:0] exp_strb(input logic [31:0] a, input int sz);
      case (sz)
         0:       return 4'(1 << (a % 4));
         1:       return ((a % 4) >= 2) ? 4'hC : 4'h3;
         2:       return 4'hF;
         default: return 4'h0;
      endcase
   endfunction

   function automatic bit exp_bad(input logic [31:0] a, input int sz);
      if (sz > 2) return 1'b1;
      return (a % (1 << sz)) != 0;
   endfunction

   task automatic check_err_pair(input string tag);
      @(negedge clk);
      check({tag, "_err1_hready"}, HREADYOUT, 1'b0);
      check({tag, "_err1_hresp"},  HRESP,     1'b1);
      check({tag, "_err1_preq"},   P_REQ,     1'b0);
      @(posedge clk); #1;
      @(negedge clk);
      check({tag, "_err2_hready"}, HREADYOUT, 1'b1);
      check({tag, "_err2_hresp"},  HRESP,     1'b1);
      check({tag, "_err2_hrdata"}, HRDATA,    hrdata_exp);
   endtask

   // perr: 0 = plain ack, 1 = P_ERR alone, 2 = P_ERR together with P_ACK
   task automatic xfer(input string tag, input logic [31:0] a, input bit wr, input int sz,
                       input logic [31:0] wd, input int d, input int perr,
                       input logic [31:0] rd);
      bit bad, ok;
      int req_cycles;
      bad = exp_bad(a, sz);
      ok  = 1'b0;
      @(posedge clk); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = a; HWRITE = wr; HSIZE = 3'(sz);
      @(posedge clk); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HADDR = $urandom; HWDATA = wd;
      if (!bad) begin
         ok = (d < TO) && (perr == 0);
         req_cycles = (d < TO) ? d + 1 : TO;
         for (int k = 0; k < req_cycles; k++) begin
            if (k == d) begin
               P_ERR = (perr != 0); P_ACK = (perr != 1); P_RDATA = rd;
            end else begin
               P_ERR = 1'b0; P_ACK = 1'b0; P_RDATA = $urandom;
            end
            @(negedge clk);
            check({tag, "_acc_preq"},   P_REQ,     1'b1);
            check({tag, "_acc_hready"}, HREADYOUT, 1'b0);
            check({tag, "_acc_hresp"},  HRESP,     1'b0);
            check({tag, "_acc_paddr"},  P_ADDR,    a);
            check({tag, "_acc_pwrite"}, P_WRITE,   wr);
            check({tag, "_acc_pwstrb"}, P_WSTRB,   exp_strb(a, sz));
            check({tag, "_acc_pwdata"}, P_WDATA,   wd);
            check({tag, "_acc_hrdata"}, HRDATA,    hrdata_exp);
            @(posedge clk); #1;
         end
         P_ACK = 1'b0; P_ERR = 1'b0;
      end
      if (ok) begin
         if (!wr) hrdata_exp = rd;
         @(negedge clk);
         check({tag, "_resp_hready"}, HREADYOUT, 1'b1);
         check({tag, "_resp_hresp"},  HRESP,     1'b0);
         check({tag, "_resp_preq"},   P_REQ,     1'b0);
         check({tag, "_resp_hrdata"}, HRDATA,    hrdata_exp);
      end else begin
         check_err_pair(tag);
      end
   endtask

   initial begin
      logic [31:0] r1, w2, a;
      int sz, d, pe;
      reset = 1'b0; HSEL = 1'b0; HADDR = '0; HWRITE = 1'b0; HTRANS = 2'b00; HSIZE = 3'd0;
      HWDATA = '0; HREADY = 1'b1; P_RDATA = '0; P_ACK = 1'b0; P_ERR = 1'b0;
      hrdata_exp = 32'd0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check("rst_hready", HREADYOUT, 1'b1);
      check("rst_hresp",  HRESP,     1'b0);
      check("rst_hrdata", HRDATA,    32'd0);
      check("rst_preq",   P_REQ,     1'b0);
      check("rst_paddr",  P_ADDR,    32'd0);
      check("rst_pwrite", P_WRITE,   1'b0);
      check("rst_pwstrb", P_WSTRB,   4'd0);
      reset = 1'b1;

      xfer("t1_word_wr", 32'h10, 1'b1, 2, 32'hDEADBEEF, 0, 0, 32'h0);
      xfer("t2_byte_rd", 32'h13, 1'b0, 0, 32'h0, 2, 0, 32'hAB000000);
      xfer("t3_half_mis", 32'h21, 1'b1, 1, 32'h1234, 0, 0, 32'h0);
      xfer("t4_timeout", 32'h40, 1'b0, 2, 32'h0, 100, 0, 32'h0);
      xfer("t4_ack_err", 32'h44, 1'b0, 2, 32'h0, 1, 2, 32'h55AA55AA);
      xfer("t4_err", 32'h48, 1'b1, 2, 32'h9, 3, 1, 32'h0);
      xfer("t4_size3", 32'h50, 1'b0, 3, 32'h0, 0, 0, 32'h0);

      // Back-to-back: second address presented during RESP of the first.
      r1 = $urandom; w2 = $urandom;
      @(posedge clk); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h0; HWRITE = 1'b0; HSIZE = 3'd2;
      @(posedge clk); #1;
      HSEL = 1'b0; HTRANS = 2'b00; P_ACK = 1'b1; P_RDATA = r1;
      @(negedge clk);
      check("t5_req1", P_REQ, 1'b1);
      @(posedge clk); #1;
      P_ACK = 1'b0; HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4; HWRITE = 1'b1;
      hrdata_exp = r1;
      @(negedge clk);
      check("t5_gap_preq",   P_REQ,     1'b0);
      check("t5_gap_hready", HREADYOUT, 1'b1);
      check("t5_gap_hrdata", HRDATA,    hrdata_exp);
      @(posedge clk); #1;
      HSEL = 1'b0; HTRANS = 2'b00; HWDATA = w2; P_ACK = 1'b1;
      @(negedge clk);
      check("t5_req2",    P_REQ,   1'b1);
      check("t5_paddr2",  P_ADDR,  32'h4);
      check("t5_pwrite2", P_WRITE, 1'b1);
      check("t5_pwdata2", P_WDATA, w2);
      @(posedge clk); #1;
      P_ACK = 1'b0;
      @(negedge clk);
      check("t5_resp_hready", HREADYOUT, 1'b1);
      check("t5_resp_preq",   P_REQ,     1'b0);
      check("t5_resp_hrdata", HRDATA,    hrdata_exp);

      // Asynchronous reset in the middle of an access.
      @(posedge clk); #1;
      HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h80; HWRITE = 1'b0; HSIZE = 3'd2;
      @(posedge clk); #1;
      HSEL = 1'b0; HTRANS = 2'b00;
      @(negedge clk);
      check("t6_pre_preq", P_REQ, 1'b1);
      @(posedge clk); #2;
      reset = 1'b0;
      #1;
      hrdata_exp = 32'd0;
      check("t6_rst_preq",   P_REQ,     1'b0);
      check("t6_rst_hready", HREADYOUT, 1'b1);
      check("t6_rst_hrdata", HRDATA,    hrdata_exp);
      @(negedge clk);
      reset = 1'b1;
      xfer("t6_after", 32'h84, 1'b0, 2, 32'h0, 1, 0, 32'hC0FFEE01);

      for (int i = 0; i < 40; i++) begin
         a  = $urandom;
         sz = $urandom_range(0, 3);
         d  = ($urandom_range(0, 7) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, 5);
         pe = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 2) : 0;
         xfer("rnd", a, 1'($urandom), sz, $urandom, d, pe, $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
